// File: rtl/alu_mp_pkg.sv
// alu_mp_pkg: command, state and ALU opcode encodings shared by the multi-precision sequencer.
package alu_mp_pkg;

    typedef enum logic [2:0] {
        CMD_ADD = 3'd0,
        CMD_SUB = 3'd1,
        CMD_AND = 3'd2,
        CMD_OR  = 3'd3,
        CMD_XOR = 3'd4,
        CMD_CMP = 3'd5
    } cmd_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_CLR = 4'b1000;

    function automatic logic is_logic(cmd_t c);
        return c inside {CMD_AND, CMD_OR, CMD_XOR};
    endfunction

    function automatic logic [3:0] alu_op(cmd_t c);
        return c == CMD_AND ? OP_AND : c == CMD_OR ? OP_OR : c == CMD_XOR ? OP_XOR : OP_ADD;
    endfunction

endpackage

// File: rtl/alu_mp_flag_acc.sv
// alu_mp_flag_acc: slice-to-slice carry chain plus Carry/Zero/Negative/Overflow accumulation.
// Overflow is only built when ALU_MP_OVF_EN is defined; otherwise it is tied 0.
module alu_mp_flag_acc
    import alu_mp_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         sub_i,
    input  logic         logic_i,
    input  logic         step_i,
    input  logic         last_i,
    input  logic         alu_a_msb_i,
    input  logic         alu_b_msb_i,
    input  logic [W-1:0] alu_out_i,
    input  logic         alu_sc_i,
    output logic         sc_o,
    output logic         carry_o,
    output logic         zero_o,
    output logic         neg_o,
    output logic         ovf_o
);

    logic chain_q, chain_d, zacc_q, zacc_d;
    logic carry_q, carry_d, zero_q, zero_d, neg_q, neg_d;
    logic slice_zero, fin;

    assign slice_zero = alu_out_i == '0;
    assign fin        = step_i && last_i;
    // Subtraction seeds the chain with 1 so ~B + 1 forms the two's complement.
    assign sc_o       = chain_q & ~logic_i;

    always_comb begin
        chain_d = clear_i ? sub_i : step_i ? alu_sc_i : chain_q;
        zacc_d  = clear_i ? 1'b1 : step_i ? zacc_q & slice_zero : zacc_q;
        carry_d = clear_i ? 1'b0 : fin ? alu_sc_i & ~logic_i : carry_q;
        zero_d  = clear_i ? 1'b0 : fin ? zacc_q & slice_zero : zero_q;
        neg_d   = clear_i ? 1'b0 : fin ? alu_out_i[W-1] : neg_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= 1'b0;
            zacc_q  <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            chain_q <= chain_d;
            zacc_q  <= zacc_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    assign carry_o = carry_q;
    assign zero_o  = zero_q;
    assign neg_o   = neg_q;

`ifdef ALU_MP_OVF_EN
    logic ovf_q, ovf_d;

    always_comb
        ovf_d = clear_i ? 1'b0 :
                fin ? ~logic_i & (alu_a_msb_i == alu_b_msb_i) & (alu_out_i[W-1] != alu_a_msb_i) : ovf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ovf_q <= 1'b0;
        else         ovf_q <= ovf_d;
    end

    assign ovf_o = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = alu_a_msb_i ^ alu_b_msb_i;
    assign ovf_o      = 1'b0;
`endif

endmodule

// File: rtl/alu_mp_sequencer.sv
// alu_mp_sequencer: drives an external W-bit ALU one slice per cycle to run N-slice arithmetic/logic.
// Signed Overflow flag is generated only when ALU_MP_OVF_EN is defined.
module alu_mp_sequencer
    import alu_mp_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   Start,
    input  logic [2:0]             Cmd,
    input  logic [$clog2(N+1)-1:0] NBytes,
    input  logic [W*N-1:0]         OpA,
    input  logic [W*N-1:0]         OpB,
    output logic [W-1:0]           AluA,
    output logic [W-1:0]           AluB,
    output logic [3:0]             AluOp,
    output logic                   AluSCIn,
    input  logic [W-1:0]           AluOut,
    input  logic                   AluSCOut,
    output logic                   Busy,
    output logic                   Done,
    output logic [W*N-1:0]         Result,
    output logic                   Carry,
    output logic                   Zero,
    output logic                   Negative,
    output logic                   Overflow,
    output logic                   IllegalCmd
);

    localparam int NW = $clog2(N + 1);
    localparam int IW = N > 1 ? $clog2(N) : 1;

    state_t                  state_q, state_d;
    cmd_t                    cmd_q, cmd_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NW-1:0]           nb_q, nb_d, nb_clamp;
    logic [N-1:0][W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
    logic                    ill_q, ill_d;
    logic                    legal, accept, run, last, inv_b, sc;

    assign legal    = Cmd <= CMD_CMP;
    assign accept   = Start && state_q == IDLE;
    assign run      = state_q == RUN;
    assign last     = run && NW'(idx_q) == nb_q - NW'(1);
    assign nb_clamp = (NBytes == '0 || NBytes > NW'(N)) ? NW'(N) : NBytes;
    assign inv_b    = cmd_q == CMD_SUB || cmd_q == CMD_CMP;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        nb_d    = nb_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        ill_d   = ill_q;
        unique case (state_q)
            IDLE: if (Start) begin
                state_d = RUN;
                idx_d   = '0;
                nb_d    = nb_clamp;
                // Illegal commands run as ADD of zeros so Result ends up 0.
                cmd_d   = legal ? cmd_t'(Cmd) : CMD_ADD;
                a_d     = legal ? OpA : '0;
                b_d     = legal ? OpB : '0;
                res_d   = (Cmd == CMD_CMP) ? res_q : '0;
                ill_d   = ill_q | ~legal;
            end
            RUN: begin
                if (cmd_q != CMD_CMP) res_d[idx_q] = AluOut;
                state_d = last ? DONE : RUN;
                idx_d   = last ? idx_q : idx_q + IW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cmd_q   <= CMD_ADD;
            idx_q   <= '0;
            nb_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            nb_q    <= nb_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ill_q   <= ill_d;
        end
    end

    assign AluOp   = run ? alu_op(cmd_q) : OP_CLR;
    assign AluA    = run ? a_q[idx_q] : '0;
    assign AluB    = run ? (inv_b ? ~b_q[idx_q] : b_q[idx_q]) : '0;
    assign AluSCIn = run & sc;

    alu_mp_flag_acc #(.W(W)) u_flag_acc (
        .clk_i       (Clk),
        .rst_ni      (Reset_n),
        .clear_i     (accept),
        .sub_i       (Cmd == CMD_SUB || Cmd == CMD_CMP),
        .logic_i     (is_logic(cmd_q)),
        .step_i      (run),
        .last_i      (last),
        .alu_a_msb_i (AluA[W-1]),
        .alu_b_msb_i (AluB[W-1]),
        .alu_out_i   (AluOut),
        .alu_sc_i    (AluSCOut),
        .sc_o        (sc),
        .carry_o     (Carry),
        .zero_o      (Zero),
        .neg_o       (Negative),
        .ovf_o       (Overflow)
    );

    assign Busy       = state_q != IDLE;
    assign Done       = state_q == DONE;
    assign Result     = res_q;
    assign IllegalCmd = ill_q;

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// tb_alu_mp_sequencer: directed vector table plus hand-written multi-cycle sequences, with an 8-bit ALU model.
module tb_alu_mp_sequencer;

`ifdef ALU_MP_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  cmd;
    logic [2:0]  nbytes;
    logic [31:0] op_a, op_b;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic [3:0]  alu_op;
    logic        alu_sc_in, alu_sc_out;
    logic        busy, done;
    logic [31:0] result;
    logic        carry, zero, negative, overflow, illegal;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_mp_sequencer #(.W(8), .N(4)) dut (
        .Clk        (clk),
        .Reset_n    (rst_n),
        .Start      (start),
        .Cmd        (cmd),
        .NBytes     (nbytes),
        .OpA        (op_a),
        .OpB        (op_b),
        .AluA       (alu_a),
        .AluB       (alu_b),
        .AluOp      (alu_op),
        .AluSCIn    (alu_sc_in),
        .AluOut     (alu_out),
        .AluSCOut   (alu_sc_out),
        .Busy       (busy),
        .Done       (done),
        .Result     (result),
        .Carry      (carry),
        .Zero       (zero),
        .Negative   (negative),
        .Overflow   (overflow),
        .IllegalCmd (illegal)
    );

    // External ALU model: ADD with carry in/out, bitwise logic ops, clear.
    logic [8:0] sum;
    always_comb begin
        sum        = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_sc_in};
        alu_out    = 8'h00;
        alu_sc_out = 1'b0;
        case (alu_op)
            4'b0000: {alu_sc_out, alu_out} = sum;
            4'b0010: alu_out = alu_a & alu_b;
            4'b0011: alu_out = alu_a | alu_b;
            4'b0100: alu_out = alu_a ^ alu_b;
            default: alu_out = 8'h00;
        endcase
    end

    typedef struct {
        logic [2:0]  cmd;
        logic [2:0]  nb;
        logic [31:0] a, b, res;
        logic        c, z, n, v, ill;
        int          lat;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Latency counted in cycles after the accepting edge; the first negedge after it is cycle 1.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic launch(input logic [2:0] c, input logic [2:0] nb, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; cmd = c; nbytes = nb; op_a = a; op_b = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        launch(v.cmd, v.nb, v.a, v.b);
        wait_done(lat);
        chk({tag, "_lat"}, lat, v.lat);
        chk({tag, "_res"}, result, v.res);
        chk({tag, "_carry"}, {31'd0, carry}, {31'd0, v.c});
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, v.z});
        chk({tag, "_neg"}, {31'd0, negative}, {31'd0, v.n});
        chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, v.v & OVF_EN});
        chk({tag, "_ill"}, {31'd0, illegal}, {31'd0, v.ill});
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        int lat, nd;
        //          cmd   nb    a             b             res           c     z     n     v     ill   lat
        vt[0]  = '{3'd0, 3'd4, 32'h00FFFFFF, 32'h00000001, 32'h01000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5};
        vt[1]  = '{3'd1, 3'd4, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5};
        vt[2]  = '{3'd0, 3'd1, 32'h00000055, 32'h00000055, 32'h000000AA, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2};
        vt[3]  = '{3'd5, 3'd4, 32'h12345678, 32'h12345678, 32'h000000AA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5};
        vt[4]  = '{3'd0, 3'd2, 32'h0000FFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3};
        vt[5]  = '{3'd2, 3'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5};
        vt[6]  = '{3'd3, 3'd3, 32'h12345678, 32'h0000000F, 32'h0034567F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4};
        vt[7]  = '{3'd4, 3'd0, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5};
        vt[8]  = '{3'd1, 3'd7, 32'h00000005, 32'h00000003, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5};
        vt[9]  = '{3'd0, 3'd4, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5};
        vt[10] = '{3'd6, 3'd2, 32'h12345678, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3};
        vt[11] = '{3'd1, 3'd1, 32'h00000080, 32'h00000001, 32'h0000007F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2};

        rst_n = 1'b0; start = 1'b0; cmd = 3'd0; nbytes = 3'd0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {28'd0, carry, zero, negative, overflow}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_aluop", {28'd0, alu_op}, 32'h8);
        chk("rst_alu_ab", {15'd0, alu_sc_in, alu_a, alu_b}, 32'd0);
        rst_n = 1'b1;

        // First slice of a SUB: inverted B and carry-in of 1.
        launch(3'd1, 3'd4, 32'h11223344, 32'h01020304);
        chk("sub_s0_aluop", {28'd0, alu_op}, 32'h0);
        chk("sub_s0_alua", {24'd0, alu_a}, 32'h44);
        chk("sub_s0_alub", {24'd0, alu_b}, 32'hFB);
        chk("sub_s0_scin", {31'd0, alu_sc_in}, 32'd1);
        chk("sub_s0_busy", {31'd0, busy}, 32'd1);
        wait_done(lat);
        chk("sub_lat", lat, 5);
        chk("sub_res", result, 32'h10203040);
        chk("sub_carry", {31'd0, carry}, 32'd1);
        @(negedge clk);
        chk("post_done", {31'd0, done}, 32'd0);
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk("post_aluop", {28'd0, alu_op}, 32'h8);

        for (int i = 0; i < 12; i++) run_vec(vt[i], $sformatf("v%0d", i));

        // Start pulsed mid-RUN must be ignored.
        launch(3'd0, 3'd4, 32'h01010101, 32'h01010101);
        @(negedge clk);
        start = 1'b1; cmd = 3'd2; op_a = 32'hFFFFFFFF; op_b = 32'h0; nbytes = 3'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("ign_lat", lat < 0 ? lat : lat + 2, 5);
        chk("ign_res", result, 32'h02020202);
        count_dones(8, nd);
        chk("ign_extra_done", nd, 0);
        chk("ign_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of RUN abandons the operation.
        launch(3'd0, 3'd4, 32'h01010101, 32'h02020202);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_illegal", {31'd0, illegal}, 32'd0);
        chk("midrst_aluop", {28'd0, alu_op}, 32'h8);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(8, nd);
        chk("midrst_no_done", nd, 0);
        launch(3'd0, 3'd4, 32'h01000000, 32'h00FFFFFF);
        wait_done(lat);
        chk("after_rst_lat", lat, 5);
        chk("after_rst_res", result, 32'h01FFFFFF);
        chk("after_rst_flags", {29'd0, carry, zero, negative}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
